// File: rtl/pixel_pkg.sv
// Shared pixel types and screen geometry for the pixel write path.
// The arbiter's optional bounds filter is enabled by PIXEL_ARB_BOUNDS_CHECK_EN.
package pixel_pkg;

   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOR_W  = 3;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

   typedef enum logic {
      GRANT_CLR = 1'b0,
      GRANT_SPR = 1'b1
   } grant_e;

   function automatic logic on_screen(input pixel_t p);
      return (int'(p.x) < SCREEN_W) && (int'(p.y) < SCREEN_H);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel buffer: head entry is visible whenever not empty.
// Outputs zero data when empty so the adapter never sees stale pixels.
module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  pixel_t        data_in,
   input  logic          pop,
   output pixel_t        data_out,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   pixel_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign count    = count_q;
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign data_out = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of clear-screen and sprite pixel writes into one VGA port.
// PIXEL_ARB_BOUNDS_CHECK_EN drops off-screen pixels and counts them.
module pixel_write_arbiter
   import pixel_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clr_valid,
   input  logic [X_W-1:0]     clr_x,
   input  logic [Y_W-1:0]     clr_y,
   input  logic [COLOR_W-1:0] clr_color,
   output logic               clr_ready,
   input  logic               spr_valid,
   input  logic [X_W-1:0]     spr_x,
   input  logic [Y_W-1:0]     spr_y,
   input  logic [COLOR_W-1:0] spr_color,
   output logic               spr_ready,
   output logic               plot,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [COLOR_W-1:0] color,
   input  logic               plot_ready,
   output logic [15:0]        dropped_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   grant_e        last_grant;
   pixel_t        in_pix;
   pixel_t        head;
   logic          full;
   logic          empty;
   logic [CW-1:0] occupancy;
   logic          pop;
   logic          can_accept;
   logic          clr_win;
   logic          xfer;
   logic          push;

   assign pop        = ~empty & plot_ready;
   assign can_accept = ~reset & (~full | pop);
   assign clr_win    = clr_valid & (~spr_valid | (last_grant == GRANT_SPR));
   assign clr_ready  = can_accept & clr_win;
   assign spr_ready  = can_accept & spr_valid & ~clr_win;
   assign xfer       = clr_ready | spr_ready;

   assign in_pix = clr_win ? {clr_x, clr_y, clr_color}
                           : {spr_x, spr_y, spr_color};

   assign plot  = ~empty;
   assign x     = head.x;
   assign y     = head.y;
   assign color = head.color;

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant <= GRANT_SPR;
      end else if (clr_ready) begin
         last_grant <= GRANT_CLR;
      end else if (spr_ready) begin
         last_grant <= GRANT_SPR;
      end
   end

`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
   logic        keep;
   logic [15:0] drop_q;

   // Off-screen pixels still handshake so the requester never stalls.
   assign keep          = on_screen(in_pix);
   assign push          = xfer & keep;
   assign dropped_count = drop_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         drop_q <= '0;
      end else if (xfer && !keep && drop_q != 16'hFFFF) begin
         drop_q <= drop_q + 16'd1;
      end
   end
`else
   assign push          = xfer;
   assign dropped_count = '0;
`endif

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .data_in  (in_pix),
      .pop      (pop),
      .data_out (head),
      .full     (full),
      .empty    (empty),
      .count    (occupancy)
   );

   a_occ_bound : assert property (@(posedge clock) disable iff (reset)
      occupancy <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: vector table, corner sequences, random vs queue model.
// Expectations follow PIXEL_ARB_BOUNDS_CHECK_EN when it is defined.
module tb_pixel_write_arbiter;
   import pixel_pkg::*;

   localparam int DEPTH = 4;
`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clr_valid = 1'b0;
   logic [8:0]  clr_x = '0;
   logic [7:0]  clr_y = '0;
   logic [2:0]  clr_color = '0;
   logic        clr_ready;
   logic        spr_valid = 1'b0;
   logic [8:0]  spr_x = '0;
   logic [7:0]  spr_y = '0;
   logic [2:0]  spr_color = '0;
   logic        spr_ready;
   logic        plot;
   logic [8:0]  x;
   logic [7:0]  y;
   logic [2:0]  color;
   logic        plot_ready = 1'b0;
   logic [15:0] dropped_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pixel_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .clr_valid     (clr_valid),
      .clr_x         (clr_x),
      .clr_y         (clr_y),
      .clr_color     (clr_color),
      .clr_ready     (clr_ready),
      .spr_valid     (spr_valid),
      .spr_x         (spr_x),
      .spr_y         (spr_y),
      .spr_color     (spr_color),
      .spr_ready     (spr_ready),
      .plot          (plot),
      .x             (x),
      .y             (y),
      .color         (color),
      .plot_ready    (plot_ready),
      .dropped_count (dropped_count)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: an ordered queue of buffered pixels.
   pixel_t q[$];
   bit     m_last_spr = 1'b1;
   int     m_drop = 0;
   bit     g_clr = 1'b0;
   bit     g_spr = 1'b0;
   bit     d_clr = 1'b0;
   bit     d_spr = 1'b0;

   task automatic tick();
      bit     pop_e, can, cg, sg;
      pixel_t p, h;
      #1;
      pop_e = (q.size() > 0) && plot_ready;
      can   = !reset && ((q.size() < DEPTH) || pop_e);
      cg    = can && clr_valid && (!spr_valid || m_last_spr);
      sg    = can && spr_valid && !cg;
      h     = (q.size() > 0) ? q[0] : '0;
      p     = cg ? {clr_x, clr_y, clr_color} : {spr_x, spr_y, spr_color};
      d_clr = clr_ready;
      d_spr = spr_ready;
      chk("clr_ready", clr_ready, cg);
      chk("spr_ready", spr_ready, sg);
      chk("plot", plot, q.size() > 0);
      chk("x", x, h.x);
      chk("y", y, h.y);
      chk("color", color, h.color);
      chk("dropped_count", dropped_count, m_drop);
      @(posedge clock);
      if (reset) begin
         q.delete();
         m_last_spr = 1'b1;
         m_drop = 0;
      end else begin
         if (pop_e) void'(q.pop_front());
         if (cg || sg) begin
            m_last_spr = sg;
            if (!BCHK || (p.x < 320 && p.y < 240)) q.push_back(p);
            else if (m_drop < 65535) m_drop++;
         end
      end
      g_clr = cg;
      g_spr = sg;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clr_valid = 1'b0;
      spr_valid = 1'b0;
      plot_ready = 1'b0;
      @(posedge clock);
      #1;
      q.delete();
      m_last_spr = 1'b1;
      m_drop = 0;
      g_clr = 1'b0;
      g_spr = 1'b0;
      reset = 1'b0;
   endtask

   typedef struct {
      bit cv; int cx; int cy; int cc;
      bit sv; int sx; int sy; int sc;
      bit pr;
      bit ecr; bit esr; bit ep; int ex; int ey; int ec;
   } vec_t;

   function automatic vec_t mk(bit cv, int cx, int cy, int cc,
                               bit sv, int sx, int sy, int sc, bit pr,
                               bit ecr, bit esr, bit ep,
                               int ex, int ey, int ec);
      vec_t v;
      v.cv = cv; v.cx = cx; v.cy = cy; v.cc = cc;
      v.sv = sv; v.sx = sx; v.sy = sy; v.sc = sc;
      v.pr = pr;
      v.ecr = ecr; v.esr = esr; v.ep = ep;
      v.ex = ex; v.ey = ey; v.ec = ec;
      return v;
   endfunction

   initial begin
      vec_t tbl[15];
      int   bx[3], by[3], bc[3];
      int   ex[3], ey[3], ec[3];
      int   n;

      tbl[0]  = mk(1,5,7,3, 0,0,0,0, 1, 1,0,0, 0,0,0);
      tbl[1]  = mk(0,0,0,0, 0,0,0,0, 1, 0,0,1, 5,7,3);
      tbl[2]  = mk(0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0);
      tbl[3]  = mk(1,1,1,1, 1,2,2,2, 0, 0,1,0, 0,0,0);
      tbl[4]  = mk(1,1,1,1, 1,3,3,3, 0, 1,0,1, 2,2,2);
      tbl[5]  = mk(1,4,4,4, 1,3,3,3, 0, 0,1,1, 2,2,2);
      tbl[6]  = mk(1,4,4,4, 1,5,5,5, 0, 1,0,1, 2,2,2);
      tbl[7]  = mk(1,6,6,6, 1,5,5,5, 0, 0,0,1, 2,2,2);
      tbl[8]  = mk(1,6,6,6, 1,5,5,5, 1, 0,1,1, 2,2,2);
      tbl[9]  = mk(1,6,6,6, 0,0,0,0, 1, 1,0,1, 1,1,1);
      tbl[10] = mk(0,0,0,0, 0,0,0,0, 1, 0,0,1, 3,3,3);
      tbl[11] = mk(0,0,0,0, 0,0,0,0, 1, 0,0,1, 4,4,4);
      tbl[12] = mk(0,0,0,0, 0,0,0,0, 1, 0,0,1, 5,5,5);
      tbl[13] = mk(0,0,0,0, 0,0,0,0, 1, 0,0,1, 6,6,6);
      tbl[14] = mk(0,0,0,0, 0,0,0,0, 1, 0,0,0, 0,0,0);

      // Power-up reset with both requesters asking.
      reset = 1'b1;
      clr_valid = 1'b1;
      spr_valid = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_clr_ready", clr_ready, 0);
      chk("rst_spr_ready", spr_ready, 0);
      chk("rst_plot", plot, 0);
      chk("rst_xyc", {x, y, color}, 0);
      chk("rst_dropped", dropped_count, 0);
      do_reset();

      // Vector table: lone clr, alternation, full FIFO, push+pop, drain.
      for (int i = 0; i < 15; i++) begin
         clr_valid = tbl[i].cv;
         clr_x = 9'(tbl[i].cx);
         clr_y = 8'(tbl[i].cy);
         clr_color = 3'(tbl[i].cc);
         spr_valid = tbl[i].sv;
         spr_x = 9'(tbl[i].sx);
         spr_y = 8'(tbl[i].sy);
         spr_color = 3'(tbl[i].sc);
         plot_ready = tbl[i].pr;
         #1;
         chk($sformatf("tbl%0d_clr_ready", i), clr_ready, tbl[i].ecr);
         chk($sformatf("tbl%0d_spr_ready", i), spr_ready, tbl[i].esr);
         chk($sformatf("tbl%0d_plot", i), plot, tbl[i].ep);
         chk($sformatf("tbl%0d_x", i), x, tbl[i].ex);
         chk($sformatf("tbl%0d_y", i), y, tbl[i].ey);
         chk($sformatf("tbl%0d_color", i), color, tbl[i].ec);
         @(posedge clock);
         #1;
      end

      // Tie from reset: clr, spr, clr, spr...
      do_reset();
      clr_valid = 1'b1; clr_x = 9'd10; clr_y = 8'd1; clr_color = 3'd1;
      spr_valid = 1'b1; spr_x = 9'd20; spr_y = 8'd2; spr_color = 3'd2;
      plot_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("tie_grant%0d", i), {d_clr, d_spr},
             (i % 2 == 0) ? 2 : 1);
         if (g_clr) clr_x = clr_x + 9'd1;
         if (g_spr) spr_x = spr_x + 9'd1;
      end
      clr_valid = 1'b0;
      spr_valid = 1'b0;
      repeat (3) tick();

      // Reset with three pixels buffered.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         clr_valid = 1'b1;
         clr_x = 9'(30 + i);
         clr_y = 8'(i);
         clr_color = 3'(i + 1);
         tick();
      end
      reset = 1'b1;
      spr_valid = 1'b1;
      tick();
      reset = 1'b0;
      clr_valid = 1'b0;
      spr_valid = 1'b0;
      #1;
      chk("mid_rst_plot", plot, 0);
      chk("mid_rst_xyc", {x, y, color}, 0);
      chk("mid_rst_readies", {clr_ready, spr_ready}, 0);
      tick();

      // Off-screen coordinates.
      do_reset();
      bx = '{320, 0, 319};
      by = '{0, 240, 239};
      bc = '{1, 2, 4};
      for (int i = 0; i < 3; i++) begin
         clr_valid = 1'b1;
         clr_x = 9'(bx[i]);
         clr_y = 8'(by[i]);
         clr_color = 3'(bc[i]);
         tick();
         chk($sformatf("bnd_accept%0d", i), d_clr, 1);
      end
      clr_valid = 1'b0;
      if (BCHK) begin
         n = 1;
         ex[0] = 319; ey[0] = 239; ec[0] = 4;
      end else begin
         n = 3;
         ex = bx; ey = by; ec = bc;
      end
      #1;
      chk("bnd_dropped", dropped_count, BCHK ? 2 : 0);
      plot_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         #1;
         chk($sformatf("bnd_plot%0d", k), plot, 1);
         chk($sformatf("bnd_x%0d", k), x, ex[k]);
         chk($sformatf("bnd_y%0d", k), y, ey[k]);
         chk($sformatf("bnd_color%0d", k), color, ec[k]);
         @(posedge clock);
      end
      #1;
      chk("bnd_drained", plot, 0);

      // Random traffic against the queue model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (!clr_valid || g_clr) begin
            clr_valid = 1'($urandom_range(0, 1));
            clr_x = 9'($urandom_range(0, 330));
            clr_y = 8'($urandom_range(0, 250));
            clr_color = 3'($urandom_range(0, 7));
         end
         if (!spr_valid || g_spr) begin
            spr_valid = 1'($urandom_range(0, 1));
            spr_x = 9'($urandom_range(0, 330));
            spr_y = 8'($urandom_range(0, 250));
            spr_color = 3'($urandom_range(0, 7));
         end
         plot_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
